// File: rtl/lab7_soc_pio_pkg.sv
// Shared definitions for the push-button PIO input controller: register
// addresses, debounce state encoding and a small bus-decode helper.
package lab7_soc_pio_pkg;

    // Avalon register map (word addresses)
    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_RSVD    = 2'd1;
    localparam logic [1:0] ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] ADDR_EDGECAP = 2'd3;

    // Per-bit debounce FSM states
    typedef enum logic {
        DB_IDLE  = 1'b0,
        DB_COUNT = 1'b1
    } db_state_t;

    // A write strobe is only meaningful while the slave is selected
    function automatic logic is_write(input logic chipselect, input logic write_n);
        return chipselect & ~write_n;
    endfunction

endpackage

// File: rtl/lab7_soc_pio_input_ctrl_if.sv
// Avalon-MM slave bus bundle between the lab7_soc interconnect and the PIO
// input controller. Read latency is one cycle; readdata is registered.
interface lab7_soc_pio_input_ctrl_if;

    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    // Interconnect side
    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    // Controller side
    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );

endinterface

// File: rtl/lab7_soc_pio_debounce_bit.sv
// One button input: two-flop synchronizer followed by a counter FSM that only
// accepts a new level once the synchronized input has disagreed with the
// accepted level for DEBOUNCE_CYCLES consecutive clocks. Any agreeing sample
// in between throws the partial count away.
module lab7_soc_pio_debounce_bit
    import lab7_soc_pio_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_WIDTH       = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw,
    output logic stable
);

    localparam logic [CNT_WIDTH-1:0] LAST_COUNT = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] ONE_COUNT  = CNT_WIDTH'(1);
    // With a one-cycle window the first disagreeing sample is already enough,
    // so the counter never leaves zero.
    localparam bit SINGLE_CYCLE = (DEBOUNCE_CYCLES == 1);

    logic                 sync1_reg;
    logic                 sync2_reg;
    logic                 stable_reg;
    logic                 stable_next;
    db_state_t            state_reg;
    db_state_t            state_next;
    logic [CNT_WIDTH-1:0] count_reg;
    logic [CNT_WIDTH-1:0] count_next;

    // Bring the asynchronous pin into the clock domain
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
        end else begin
            sync1_reg <= raw;
            sync2_reg <= sync1_reg;
        end
    end

    // Debounce state, counter and accepted level
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg  <= DB_IDLE;
            count_reg  <= '0;
            stable_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            count_reg  <= count_next;
            stable_reg <= stable_next;
        end
    end

    // Next-state logic: count consecutive disagreements, reject on any agreement
    always_comb begin
        state_next  = state_reg;
        count_next  = count_reg;
        stable_next = stable_reg;
        case (state_reg)
            DB_IDLE: begin
                count_next = '0;
                if (sync2_reg != stable_reg) begin
                    if (SINGLE_CYCLE) begin
                        stable_next = sync2_reg;
                    end else begin
                        state_next = DB_COUNT;
                        count_next = ONE_COUNT;
                    end
                end
            end
            DB_COUNT: begin
                if (sync2_reg == stable_reg) begin
                    state_next = DB_IDLE;
                    count_next = '0;
                end else if (count_reg == LAST_COUNT) begin
                    stable_next = sync2_reg;
                    state_next  = DB_IDLE;
                    count_next  = '0;
                end else begin
                    count_next = count_reg + ONE_COUNT;
                end
            end
        endcase
    end

    assign stable = stable_reg;

endmodule

// File: rtl/lab7_soc_pio_input_ctrl.sv
// Avalon-MM slave for the Accumulate/Reset push buttons. Each in_port bit is
// debounced into a clean level; rising edges of that level are latched into a
// write-1-to-clear capture register that drives a maskable interrupt, so
// software sees exactly one event per press.
module lab7_soc_pio_input_ctrl
    import lab7_soc_pio_pkg::*;
#(
    parameter int DATA_WIDTH      = 8,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_WIDTH       = 16
) (
    input  logic                        clk,
    input  logic                        reset_n,
    lab7_soc_pio_input_ctrl_if.slave    bus,
    input  logic [DATA_WIDTH-1:0]       in_port,
    output logic                        irq
);

    logic [DATA_WIDTH-1:0] stable;
    logic [DATA_WIDTH-1:0] stable_d_reg;
    logic [DATA_WIDTH-1:0] irqmask_reg;
    logic [DATA_WIDTH-1:0] irqmask_next;
    logic [DATA_WIDTH-1:0] edgecap_reg;
    logic [DATA_WIDTH-1:0] edgecap_next;
    logic [DATA_WIDTH-1:0] edge_set;
    logic [DATA_WIDTH-1:0] w1c_mask;
    logic [DATA_WIDTH-1:0] wdata;
    logic [31:0]           readdata_reg;
    logic [31:0]           readdata_next;
    logic                  irq_reg;
    logic                  irq_next;
    logic                  write_en;

    // Upper writedata bits have no register behind them
    wire unused_wdata = &{1'b0, bus.writedata};

    // One synchronizer + debouncer per input bit
    generate
        for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_bit
            lab7_soc_pio_debounce_bit #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .CNT_WIDTH       (CNT_WIDTH)
            ) u_debounce (
                .clk     (clk),
                .reset_n (reset_n),
                .raw     (in_port[gi]),
                .stable  (stable[gi])
            );
        end
    endgenerate

    // Register file, edge detect, read mux and interrupt update
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            stable_d_reg <= '0;
            irqmask_reg  <= '0;
            edgecap_reg  <= '0;
            readdata_reg <= '0;
            irq_reg      <= 1'b0;
        end else begin
            stable_d_reg <= stable;
            irqmask_reg  <= irqmask_next;
            edgecap_reg  <= edgecap_next;
            readdata_reg <= readdata_next;
            irq_reg      <= irq_next;
        end
    end

    // Bus decode and next values; a new rising edge overrides a same-cycle clear
    always_comb begin
        write_en      = is_write(bus.chipselect, bus.write_n);
        wdata         = bus.writedata[DATA_WIDTH-1:0];
        edge_set      = stable & ~stable_d_reg;
        w1c_mask      = '0;
        irqmask_next  = irqmask_reg;
        if (write_en && (bus.address == ADDR_EDGECAP)) begin
            w1c_mask = wdata;
        end
        if (write_en && (bus.address == ADDR_IRQMASK)) begin
            irqmask_next = wdata;
        end
        edgecap_next  = (edgecap_reg & ~w1c_mask) | edge_set;
        irq_next      = |(edgecap_reg & irqmask_reg);
        readdata_next = '0;
        case (bus.address)
            ADDR_DATA:    readdata_next[DATA_WIDTH-1:0] = stable;
            ADDR_RSVD:    readdata_next                 = '0;
            ADDR_IRQMASK: readdata_next[DATA_WIDTH-1:0] = irqmask_reg;
            ADDR_EDGECAP: readdata_next[DATA_WIDTH-1:0] = edgecap_reg;
        endcase
    end

    assign bus.readdata = readdata_reg;
    assign irq          = irq_reg;

endmodule

// File: tb/tb_lab7_soc_pio_input_ctrl.sv
// Bench for the push-button PIO controller with a 4-cycle debounce window.
// A behavioural model tracks the last few sampled pin values and accepts a
// level once the delayed window is uniform; outputs are compared every cycle,
// and a set of directed scenarios pins exact latencies with literal values.
module tb_lab7_soc_pio_input_ctrl;

    localparam int DW = 8;
    localparam int DB = 4;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [DW-1:0] in_port;
    logic          irq;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    lab7_soc_pio_input_ctrl_if bus ();

    lab7_soc_pio_input_ctrl #(
        .DATA_WIDTH      (DW),
        .DEBOUNCE_CYCLES (DB),
        .CNT_WIDTH       (4)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus),
        .in_port (in_port),
        .irq     (irq)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // m_hist[0] is the pin value sampled at the most recent edge. The accepted
    // level becomes v once the samples two..DB+1 edges old all equal v.
    logic [DW-1:0] m_hist [0:DB];
    logic [DW-1:0] m_stable, m_stable_d, m_edgecap, m_irqmask;
    logic [DW-1:0] m_ones, m_zeros, m_w1c;
    logic [31:0]   m_readdata;
    logic          m_irq;
    logic          m_wr;
    logic          m_started = 1'b0;

    always_comb begin
        m_ones  = '1;
        m_zeros = '1;
        for (int k = 1; k <= DB; k++) begin
            m_ones  = m_ones & m_hist[k];
            m_zeros = m_zeros & ~m_hist[k];
        end
        m_wr  = bus.chipselect && !bus.write_n;
        m_w1c = (m_wr && bus.address == 2'd3) ? bus.writedata[DW-1:0] : '0;
    end

    always @(posedge clk) begin
        m_started <= 1'b1;
        if (!reset_n) begin
            for (int k = 0; k <= DB; k++) m_hist[k] <= '0;
            m_stable   <= '0;
            m_stable_d <= '0;
            m_edgecap  <= '0;
            m_irqmask  <= '0;
            m_irq      <= 1'b0;
            m_readdata <= '0;
        end else begin
            m_hist[0] <= in_port;
            for (int k = 1; k <= DB; k++) m_hist[k] <= m_hist[k-1];
            m_stable   <= (m_stable & ~m_zeros) | m_ones;
            m_stable_d <= m_stable;
            m_edgecap  <= (m_edgecap & ~m_w1c) | (m_stable & ~m_stable_d);
            if (m_wr && bus.address == 2'd2) m_irqmask <= bus.writedata[DW-1:0];
            m_irq <= |(m_edgecap & m_irqmask);
            case (bus.address)
                2'd0:    m_readdata <= {24'b0, m_stable};
                2'd2:    m_readdata <= {24'b0, m_irqmask};
                2'd3:    m_readdata <= {24'b0, m_edgecap};
                default: m_readdata <= 32'b0;
            endcase
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (m_started) begin
            check("model readdata", bus.readdata, m_readdata);
            check("model irq", {31'b0, irq}, {31'b0, m_irq});
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic bus_write(input logic [1:0] addr, input logic [31:0] data);
        bus.address    = addr;
        bus.writedata  = data;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        $display("txn write addr=%0d data=%h", addr, data);
        @(negedge clk);
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        reset_n        = 1'b0;
        in_port        = 8'hFF;
        bus.address    = 2'd0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = 32'h0;

        // Reset with all buttons pressed
        wait_cycles(3);
        check("reset readdata", bus.readdata, 32'h0);
        check("reset irq", {31'b0, irq}, 32'h0);
        reset_n = 1'b1;
        wait_cycles(1);
        check("release DATA early", bus.readdata, 32'h0);
        wait_cycles(5);
        check("release DATA before accept", bus.readdata, 32'h0);
        wait_cycles(1);
        check("release DATA accepted", bus.readdata, 32'h000000FF);
        bus.address = 2'd3;
        wait_cycles(1);
        check("release EDGECAPTURE", bus.readdata, 32'h000000FF);
        $display("txn read addr=3 data=%h", bus.readdata);

        // Release all buttons: falling edges must not be captured
        bus_write(2'd3, 32'hFF);
        in_port = 8'h00;
        wait_cycles(12);
        bus.address = 2'd3;
        wait_cycles(1);
        check("falling not captured", bus.readdata, 32'h0);

        // Clean press on bit0 with interrupts masked
        in_port[0]  = 1'b1;
        bus.address = 2'd0;
        wait_cycles(7);
        check("press DATA", bus.readdata, 32'h01);
        bus.address = 2'd3;
        wait_cycles(1);
        check("press EDGECAPTURE", bus.readdata, 32'h01);
        check("press irq masked", {31'b0, irq}, 32'h0);

        // W1C landing on the same edge that sets bit0
        in_port = 8'h00;
        wait_cycles(10);
        bus_write(2'd3, 32'hFF);
        in_port = 8'h01;
        wait_cycles(6);
        bus_write(2'd3, 32'h01);
        wait_cycles(1);
        check("collision set wins", bus.readdata, 32'h01);
        bus_write(2'd3, 32'h01);

        // Interrupt enabled on bit0
        bus_write(2'd2, 32'h01);
        in_port = 8'h00;
        wait_cycles(10);
        bus_write(2'd3, 32'hFF);
        in_port = 8'h01;
        wait_cycles(7);
        check("irq before edge", {31'b0, irq}, 32'h0);
        wait_cycles(1);
        check("irq asserted", {31'b0, irq}, 32'h1);
        bus_write(2'd3, 32'h01);
        check("irq during clear", {31'b0, irq}, 32'h1);
        wait_cycles(1);
        check("irq cleared", {31'b0, irq}, 32'h0);

        // Bounce on bit1: runs of two never reach the window
        for (int k = 0; k < 4; k++) begin
            in_port[1] = (k % 2 == 0);
            wait_cycles(2);
        end
        in_port[1] = 1'b0;
        wait_cycles(10);
        bus.address = 2'd0;
        wait_cycles(1);
        check("bounce DATA", bus.readdata & 32'h2, 32'h0);
        bus.address = 2'd3;
        wait_cycles(1);
        check("bounce EDGECAPTURE", bus.readdata & 32'h2, 32'h0);

        // Readback of IRQMASK, reserved address reads 0 and ignores writes
        bus_write(2'd2, 32'hFFFF_FFA5);
        wait_cycles(1);
        check("IRQMASK readback", bus.readdata, 32'h000000A5);
        bus.address = 2'd1;
        wait_cycles(1);
        check("reserved reads 0", bus.readdata, 32'h0);
        bus_write(2'd1, 32'hFFFF_FFFF);
        bus.address = 2'd2;
        wait_cycles(1);
        check("reserved write ignored", bus.readdata, 32'h000000A5);

        // Randomized traffic checked by the model
        for (int c = 0; c < 4000; c++) begin
            int b;
            reset_n = ($urandom_range(0, 599) != 0);
            if ($urandom_range(0, 5) == 0) begin
                b = $urandom_range(0, DW - 1);
                in_port[b] = ~in_port[b];
            end
            if ($urandom_range(0, 149) == 0) in_port = DW'($urandom);
            bus.address    = 2'($urandom_range(0, 3));
            bus.chipselect = ($urandom_range(0, 3) == 0);
            bus.write_n    = ($urandom_range(0, 2) != 0);
            bus.writedata  = $urandom;
            if (bus.chipselect && !bus.write_n)
                $display("txn write addr=%0d data=%h", bus.address, bus.writedata);
            @(negedge clk);
        end
        reset_n        = 1'b1;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        wait_cycles(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
